// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between requester A (EX stage) and
// requester B (branch/address helper) with round-robin arbitration.
//
// One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Operands are registered onto the ALU, held for ALU_LAT cycles, then the
// result and zero flag are captured and returned to the owning port.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   a_valid / a_ready             A request handshake (a_ready combinational)
//   a_r1, a_r2, a_ctrl            A operands and ALU control code
//   a_beq, a_bne                  A branch-compare flags
//   a_resp_valid / a_resp_ready   A response handshake
//   b_*                           same set for requester B
//   resp_result, resp_zero        shared response payload for the owner
//   alu_r1, alu_r2, alu_ctrl      registered ALU operand/control inputs
//   alu_beq, alu_bne              registered ALU branch flags
//   alu_result, alu_zero          ALU outputs
module alu_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_r1,
  input  logic [31:0] a_r2,
  input  logic [3:0]  a_ctrl,
  input  logic        a_beq,
  input  logic        a_bne,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,

  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_r1,
  input  logic [31:0] b_r2,
  input  logic [3:0]  b_ctrl,
  input  logic        b_beq,
  input  logic        b_bne,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,

  output logic [31:0] resp_result,
  output logic        resp_zero,

  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [3:0]  alu_ctrl,
  output logic        alu_beq,
  output logic        alu_bne,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  state_t             state;
  port_t              owner;
  port_t              last_grant;
  logic [CNT_W-1:0]   lat_cnt;

  logic               grant_a_c;
  logic               grant_b_c;
  logic               owner_resp_ready_c;

  // Round-robin pick: a lone requester wins; on a tie the port that was not
  // served last wins.
  always_comb begin
    grant_a_c = a_valid && (!b_valid || (last_grant == PORT_B));
    grant_b_c = b_valid && (!a_valid || (last_grant == PORT_A));
    owner_resp_ready_c = (owner == PORT_A) ? a_resp_ready : b_resp_ready;
  end

  // Readys are gated by reset so every output reads 0 while reset is held.
  assign a_ready = (state == IDLE) && !reset && grant_a_c;
  assign b_ready = (state == IDLE) && !reset && grant_b_c;

  // Arbitration FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= PORT_A;
      last_grant   <= PORT_B;
      lat_cnt      <= '0;
      alu_r1       <= '0;
      alu_r2       <= '0;
      alu_ctrl     <= '0;
      alu_beq      <= 1'b0;
      alu_bne      <= 1'b0;
      resp_result  <= '0;
      resp_zero    <= 1'b0;
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a_c) begin
            alu_r1   <= a_r1;
            alu_r2   <= a_r2;
            alu_ctrl <= a_ctrl;
            alu_beq  <= a_beq;
            alu_bne  <= a_bne;
            owner    <= PORT_A;
            lat_cnt  <= CNT_W'(ALU_LAT - 1);
            state    <= EXEC;
          end else if (grant_b_c) begin
            alu_r1   <= b_r1;
            alu_r2   <= b_r2;
            alu_ctrl <= b_ctrl;
            alu_beq  <= b_beq;
            alu_bne  <= b_bne;
            owner    <= PORT_B;
            lat_cnt  <= CNT_W'(ALU_LAT - 1);
            state    <= EXEC;
          end
        end

        // Hold operands on the ALU until the latency count expires.
        EXEC: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end else begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
            if (owner == PORT_A) begin
              a_resp_valid <= 1'b1;
            end else begin
              b_resp_valid <= 1'b1;
            end
            state <= RESP;
          end
        end

        // Only the owner's resp_ready completes the response.
        RESP: begin
          if (owner_resp_ready_c) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            last_grant   <= owner;
            alu_beq      <= 1'b0;
            alu_bne      <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU answers the DUT's ALU
// port; expected responses are queued at request handshake and compared at
// response handshake.
module tb_alu_arbiter;

  localparam int unsigned ALU_LAT = 3;

  logic        clk;
  logic        reset;
  logic        a_valid, a_ready, a_beq, a_bne, a_resp_valid, a_resp_ready;
  logic [31:0] a_r1, a_r2;
  logic [3:0]  a_ctrl;
  logic        b_valid, b_ready, b_beq, b_bne, b_resp_valid, b_resp_ready;
  logic [31:0] b_r1, b_r2;
  logic [3:0]  b_ctrl;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [31:0] alu_r1, alu_r2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_beq, alu_bne, alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          port;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  bit   grant_log[$];

  alu_arbiter #(.ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_r1(a_r1), .a_r2(a_r2),
    .a_ctrl(a_ctrl), .a_beq(a_beq), .a_bne(a_bne),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .b_valid(b_valid), .b_ready(b_ready), .b_r1(b_r1), .b_r2(b_r2),
    .b_ctrl(b_ctrl), .b_beq(b_beq), .b_bne(b_bne),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_ctrl(alu_ctrl),
    .alu_beq(alu_beq), .alu_bne(alu_bne),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {zero, result}; beq takes precedence over bne.
  function automatic logic [32:0] alu_model(input logic [31:0] r1, r2,
                                            input logic [3:0] ctrl,
                                            input logic beq, bne);
    logic [31:0] res;
    logic        z;
    case (ctrl)
      4'b0000: res = r1 & r2;
      4'b0001: res = r1 | r2;
      4'b0010: res = r1 + r2;
      4'b0110: res = r1 - r2;
      4'b0111: res = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0;
      4'b1100: res = ~(r1 | r2);
      default: res = 32'd0;
    endcase
    if (beq)      z = (r1 == r2);
    else if (bne) z = (r1 != r2);
    else          z = (res == 32'd0);
    return {z, res};
  endfunction

  always_comb begin
    {alu_zero, alu_result} = alu_model(alu_r1, alu_r2, alu_ctrl, alu_beq, alu_bne);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_resp(input bit port);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("resp_unexpected", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("resp_port", 64'(port), 64'(e.port));
      check("resp_result", 64'(resp_result), 64'(e.result));
      check("resp_zero", 64'(resp_zero), 64'(e.zero));
    end
  endtask

  // Monitor: record request handshakes, check response handshakes.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("resp_exclusive", 64'(a_resp_valid && b_resp_valid), 64'd0);
      if (a_valid && a_ready) begin
        exp_q.push_back('{1'b0, alu_model(a_r1, a_r2, a_ctrl, a_beq, a_bne) & 33'h0_FFFF_FFFF,
                          alu_model(a_r1, a_r2, a_ctrl, a_beq, a_bne) >> 32});
        grant_log.push_back(1'b0);
      end
      if (b_valid && b_ready) begin
        exp_q.push_back('{1'b1, alu_model(b_r1, b_r2, b_ctrl, b_beq, b_bne) & 33'h0_FFFF_FFFF,
                          alu_model(b_r1, b_r2, b_ctrl, b_beq, b_bne) >> 32});
        grant_log.push_back(1'b1);
      end
      if (a_resp_valid && a_resp_ready) compare_resp(1'b0);
      if (b_resp_valid && b_resp_ready) compare_resp(1'b1);
    end
  end

  // Present a request and hold valid until accepted; t0 = handshake cycle.
  task automatic issue(input bit port, input logic [31:0] r1, r2,
                       input logic [3:0] ctrl, input logic beq, bne,
                       output int t0);
    bit got;
    got = 1'b0;
    t0  = 0;
    if (!port) begin
      a_r1 = r1; a_r2 = r2; a_ctrl = ctrl; a_beq = beq; a_bne = bne; a_valid = 1'b1;
    end else begin
      b_r1 = r1; b_r2 = r2; b_ctrl = ctrl; b_beq = beq; b_bne = bne; b_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((!port && a_ready) || (port && b_ready)) begin
        got = 1'b1;
        t0  = cyc;
        break;
      end
    end
    if (!got) check(port ? "b_grant_timeout" : "a_grant_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!port) a_valid = 1'b0;
    else       b_valid = 1'b0;
  endtask

  // Wait until every queued expectation has been answered.
  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int          t0;
  int          t_dummy;
  logic [31:0] held;
  bit          seen;
  bit          exp_order[6];

  initial begin
    reset = 1'b1;
    a_valid = 0; a_r1 = 0; a_r2 = 0; a_ctrl = 0; a_beq = 0; a_bne = 0; a_resp_ready = 1;
    b_valid = 0; b_r1 = 0; b_r2 = 0; b_ctrl = 0; b_beq = 0; b_bne = 0; b_resp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_a_resp_valid", 64'(a_resp_valid), 64'd0);
    check("rst_b_resp_valid", 64'(b_resp_valid), 64'd0);
    check("rst_resp_result", 64'(resp_result), 64'd0);
    check("rst_alu_r1", 64'(alu_r1), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    reset = 1'b0;

    // Single ADD with latency measurement.
    issue(1'b0, 32'd5, 32'd7, 4'b0010, 1'b0, 1'b0, t0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t1_resp_seen", 64'(seen), 64'd1);
    check("t1_latency", 64'(cyc - t0), 64'(ALU_LAT + 1));
    check("t1_result", 64'(resp_result), 64'd12);
    drain("t1_drain");
    check("t1_hold_alu_r1", 64'(alu_r1), 64'd5);

    // Contention from reset: A wins first, then B.
    do_reset();
    grant_log.delete();
    fork
      issue(1'b0, 32'd9, 32'd9, 4'b0110, 1'b0, 1'b0, t_dummy);
      issue(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001, 1'b0, 1'b0, t_dummy);
    join
    drain("t2_drain");
    check("t2_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("t2_first", 64'(grant_log[0]), 64'd0);
      check("t2_second", 64'(grant_log[1]), 64'd1);
    end
    check("t2_last_result", 64'(resp_result), 64'h0000_00FF);

    // Fairness under continuous contention.
    grant_log.delete();
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fork
      for (int k = 0; k < 3; k++)
        issue(1'b0, 32'(k + 1), 32'd3, 4'b0010, 1'b0, 1'b0, t_dummy);
      for (int k = 0; k < 3; k++)
        issue(1'b1, 32'(k + 10), 32'd4, 4'b0110, 1'b0, 1'b0, t_dummy);
    join
    drain("t3_drain");
    check("t3_grants", 64'(grant_log.size()), 64'd6);
    if (grant_log.size() == 6) begin
      for (int k = 0; k < 6; k++)
        check($sformatf("t3_order%0d", k), 64'(grant_log[k]), 64'(exp_order[k]));
    end

    // Branch flags on B.
    issue(1'b1, 32'h1234, 32'h1234, 4'b0110, 1'b1, 1'b0, t_dummy);
    drain("t4_beq_drain");
    check("t4_beq_zero", 64'(resp_zero), 64'd1);
    issue(1'b1, 32'h1234, 32'h1234, 4'b0110, 1'b0, 1'b1, t_dummy);
    drain("t4_bne_drain");
    check("t4_bne_zero", 64'(resp_zero), 64'd0);
    check("t4_beq_cleared", 64'(alu_bne), 64'd0);

    // Backpressure on A while B waits.
    a_resp_ready = 1'b0;
    issue(1'b0, 32'd100, 32'd23, 4'b0010, 1'b0, 1'b0, t_dummy);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_resp_seen", 64'(seen), 64'd1);
    held = resp_result;
    check("t5_result", 64'(held), 64'd123);
    @(posedge clk);
    #1;
    b_r1 = 32'h0000_FF00; b_r2 = 32'h0000_0FF0; b_ctrl = 4'b0000; b_beq = 0; b_bne = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_valid", 64'(a_resp_valid), 64'd1);
      check("t5_stall_result", 64'(resp_result), 64'(held));
      check("t5_stall_b_ready", 64'(b_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    a_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_idle_b_ready", 64'(b_ready), 64'd1);
    check("t5_resp_dropped", 64'(a_resp_valid), 64'd0);
    check("t5_result_kept", 64'(resp_result), 64'(held));
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    drain("t5_drain");
    check("t5_b_result", 64'(resp_result), 64'h0000_0F00);

    // Reset while the operation is still counting down.
    issue(1'b0, 32'h11, 32'h22, 4'b0010, 1'b0, 1'b0, t_dummy);
    @(posedge clk);
    #1;
    a_valid = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_alu_r1", 64'(alu_r1), 64'd0);
    check("t6_alu_ctrl", 64'(alu_ctrl), 64'd0);
    check("t6_resp_result", 64'(resp_result), 64'd0);
    check("t6_resp_zero", 64'(resp_zero), 64'd0);
    check("t6_a_ready", 64'(a_ready), 64'd0);
    check("t6_a_resp_valid", 64'(a_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < int'(ALU_LAT) + 4; i++) begin
      @(negedge clk);
      check("t6_no_resp", 64'(a_resp_valid || b_resp_valid), 64'd0);
    end
    issue(1'b0, 32'd40, 32'd2, 4'b0010, 1'b0, 1'b0, t_dummy);
    drain("t6_drain");
    check("t6_after_result", 64'(resp_result), 64'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
